fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 46 ++++
 rtl/seq_counter.sv | 34 +++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its
// sequence counter.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_EXEC = 3'd5
   } state_e;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_TR   = 3'd6;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   localparam logic [2:0] OPC_IO = 3'd7;

   localparam int              SC_W   = 4;
   localparam logic [SC_W-1:0] SC_MAX = '1;

   typedef struct packed {
      logic       ar_load;
      logic       ar_inc;
      logic       ar_clr;
      logic       pc_load;
      logic       pc_inc;
      logic       pc_clr;
      logic       ir_load;
      logic       mem_rd;
      logic       exec_start;
      logic [2:0] bus_sel;
   } ctrl_t;

   // I/O instructions reuse the I bit, so they never take the indirect cycle.
   function automatic logic needs_indirect(input logic i_flag, input logic [2:0] opc);
      return i_flag && (opc != OPC_IO);
   endfunction

endpackage

// File: rtl/seq_counter.sv
// Saturating cycle counter used to report the position within an instruction.
module seq_counter
   import fetch_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            inc,
   output logic [SC_W-1:0] cnt
);

   logic [SC_W-1:0] cnt_q;
   logic [SC_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != SC_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/indirect sequencer: walks one instruction from PC fetch to the
// hand-off to the execute unit, driving AR/PC/IR strobes and the bus select.
//
// state | meaning
// IDLE  | stopped; clr_req clears AR/PC, run starts a fetch
// T0    | AR <- PC
// T1    | memory read of the instruction; IR <- MEM, PC++ on ack
// T2    | AR <- IR address field, latch opcode and I bit
// T3    | indirect read; AR <- MEM on ack
// EXEC  | execute unit owns the instruction until exec_done
module fetch_sequencer
   import fetch_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        clr_req,
   input  logic [15:0] ir_in,
   input  logic        mem_ack,
   input  logic        exec_done,
   output logic        ar_load,
   output logic        ar_inc,
   output logic        ar_clr,
   output logic        pc_load,
   output logic        pc_inc,
   output logic        pc_clr,
   output logic        ir_load,
   output logic        mem_rd,
   output logic [2:0]  bus_sel,
   output logic        exec_start,
   output logic [2:0]  d_op,
   output logic        i_bit,
   output logic [3:0]  sc,
   output logic        busy
);

   state_e     state_q;
   state_e     state_d;
   logic       exec_first_q;
   logic       exec_first_d;
   logic [2:0] d_op_q;
   logic [2:0] d_op_d;
   logic       i_bit_q;
   logic       i_bit_d;
   ctrl_t      ctrl;
   logic       sc_clr;
   logic       sc_inc;

   // Only the I bit and opcode are decoded here; the address field goes over the bus.
   logic unused_ir_addr;
   assign unused_ir_addr = ^ir_in[11:0];

   always_comb begin
      ctrl    = '0;
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               ctrl.ar_clr = 1'b1;
               ctrl.pc_clr = 1'b1;
            end else if (run) begin
               state_d = ST_T0;
            end
         end
         ST_T0: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.ar_load = 1'b1;
            state_d      = ST_T1;
         end
         ST_T1: begin
            ctrl.mem_rd  = 1'b1;
            ctrl.bus_sel = BUS_MEM;
            if (mem_ack) begin
               ctrl.ir_load = 1'b1;
               ctrl.pc_inc  = 1'b1;
               state_d      = ST_T2;
            end
         end
         ST_T2: begin
            ctrl.bus_sel = BUS_IR;
            ctrl.ar_load = 1'b1;
            state_d      = needs_indirect(ir_in[15], ir_in[14:12]) ? ST_T3 : ST_EXEC;
         end
         ST_T3: begin
            ctrl.mem_rd  = 1'b1;
            ctrl.bus_sel = BUS_MEM;
            if (mem_ack) begin
               ctrl.ar_load = 1'b1;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ctrl.exec_start = exec_first_q;
            if (exec_done) begin
               state_d = run ? ST_T0 : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // exec_start must be a single pulse even if EXEC lasts many cycles.
   always_comb begin
      exec_first_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
      d_op_d       = d_op_q;
      i_bit_d      = i_bit_q;
      if (state_q == ST_T2) begin
         d_op_d  = ir_in[14:12];
         i_bit_d = ir_in[15];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         exec_first_q <= 1'b0;
         d_op_q       <= 3'd0;
         i_bit_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         exec_first_q <= exec_first_d;
         d_op_q       <= d_op_d;
         i_bit_q      <= i_bit_d;
      end
   end

   // The count restarts at every T0 so it always reads 0 at the start of a fetch.
   assign sc_clr = (state_d == ST_IDLE) || (state_d == ST_T0);
   assign sc_inc = !sc_clr;

   seq_counter u_seq_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sc_clr),
      .inc   (sc_inc),
      .cnt   (sc)
   );

   assign ar_load    = ctrl.ar_load;
   assign ar_inc     = ctrl.ar_inc;
   assign ar_clr     = ctrl.ar_clr;
   assign pc_load    = ctrl.pc_load;
   assign pc_inc     = ctrl.pc_inc;
   assign pc_clr     = ctrl.pc_clr;
   assign ir_load    = ctrl.ir_load;
   assign mem_rd     = ctrl.mem_rd;
   assign bus_sel    = ctrl.bus_sel;
   assign exec_start = ctrl.exec_start;
   assign d_op       = d_op_q;
   assign i_bit      = i_bit_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: builds a per-cycle plan of inputs and expected outputs
// from instruction-level parameters, then replays it against the sequencer.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        clr_req;
   logic [15:0] ir_in;
   logic        mem_ack;
   logic        exec_done;
   logic        ar_load, ar_inc, ar_clr;
   logic        pc_load, pc_inc, pc_clr;
   logic        ir_load;
   logic        mem_rd;
   logic [2:0]  bus_sel;
   logic        exec_start;
   logic [2:0]  d_op;
   logic        i_bit;
   logic [3:0]  sc;
   logic        busy;

   fetch_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .clr_req    (clr_req),
      .ir_in      (ir_in),
      .mem_ack    (mem_ack),
      .exec_done  (exec_done),
      .ar_load    (ar_load),
      .ar_inc     (ar_inc),
      .ar_clr     (ar_clr),
      .pc_load    (pc_load),
      .pc_inc     (pc_inc),
      .pc_clr     (pc_clr),
      .ir_load    (ir_load),
      .mem_rd     (mem_rd),
      .bus_sel    (bus_sel),
      .exec_start (exec_start),
      .d_op       (d_op),
      .i_bit      (i_bit),
      .sc         (sc),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, run, clr_req, mem_ack, exec_done;
      logic [15:0] ir;
      bit          chk;
      logic [2:0]  bus;
      logic        ar_load, ar_clr, pc_inc, pc_clr, ir_load, mem_rd, exec_start, busy;
      logic [2:0]  d_op;
      logic        i_bit;
      logic [3:0]  sc;
      string       tag;
   } cyc_t;

   cyc_t       plan[$];
   logic [2:0] m_dop;
   logic       m_ibit;
   bit         chained;
   int         n_cmp;
   int         n_mis;

   function automatic cyc_t new_cyc();
      cyc_t c;
      c.rst_n      = 1'b1;
      c.run        = 1'($urandom);
      c.clr_req    = 1'($urandom);
      c.mem_ack    = 1'($urandom);
      c.exec_done  = 1'($urandom);
      c.ir         = 16'($urandom);
      c.chk        = 1'b1;
      c.bus        = 3'd0;
      c.ar_load    = 1'b0;
      c.ar_clr     = 1'b0;
      c.pc_inc     = 1'b0;
      c.pc_clr     = 1'b0;
      c.ir_load    = 1'b0;
      c.mem_rd     = 1'b0;
      c.exec_start = 1'b0;
      c.busy       = 1'b0;
      c.d_op       = m_dop;
      c.i_bit      = m_ibit;
      c.sc         = 4'd0;
      c.tag        = "idle";
      return c;
   endfunction

   function automatic logic [3:0] sat15(input int n);
      return (n > 15) ? 4'd15 : 4'(n);
   endfunction

   task automatic p_reset();
      cyc_t c;
      c       = new_cyc();
      c.rst_n = 1'b0;
      c.chk   = 1'b0;
      c.tag   = "reset";
      plan.push_back(c);
      m_dop   = 3'd0;
      m_ibit  = 1'b0;
      chained = 1'b0;
   endtask

   task automatic p_idle(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c         = new_cyc();
         c.run     = 1'b0;
         c.clr_req = 1'b0;
         plan.push_back(c);
      end
   endtask

   task automatic p_clr(input logic run_v);
      cyc_t c;
      c         = new_cyc();
      c.run     = run_v;
      c.clr_req = 1'b1;
      c.ar_clr  = 1'b1;
      c.pc_clr  = 1'b1;
      c.tag     = "clr";
      plan.push_back(c);
   endtask

   // One instruction: w1/w3 = wait cycles before the ack, we = cycles before exec_done.
   task automatic p_instr(input logic [15:0] ir, input int w1, input int w3, input int we,
                          input logic run_after, input int abort_at);
      cyc_t c;
      cyc_t q[$];
      int   idx;
      bit   ind;
      if (!chained) begin
         c         = new_cyc();
         c.run     = 1'b1;
         c.clr_req = 1'b0;
         c.tag     = "start";
         plan.push_back(c);
      end
      idx = 0;
      c = new_cyc(); c.busy = 1; c.bus = 3'd2; c.ar_load = 1; c.sc = 0; c.tag = "t0";
      q.push_back(c); idx++;
      for (int j = 0; j <= w1; j++) begin
         c = new_cyc(); c.busy = 1; c.mem_rd = 1; c.bus = 3'd7; c.tag = "t1";
         c.mem_ack = (j == w1);
         c.ir_load = (j == w1);
         c.pc_inc  = (j == w1);
         c.sc = sat15(idx); q.push_back(c); idx++;
      end
      c = new_cyc(); c.busy = 1; c.bus = 3'd5; c.ar_load = 1; c.ir = ir; c.tag = "t2";
      c.sc = sat15(idx); q.push_back(c); idx++;
      m_dop  = ir[14:12];
      m_ibit = ir[15];
      ind = ir[15] && (ir[14:12] != 3'd7);
      if (ind) begin
         for (int j = 0; j <= w3; j++) begin
            c = new_cyc(); c.busy = 1; c.mem_rd = 1; c.bus = 3'd7; c.tag = "t3";
            c.mem_ack = (j == w3);
            c.ar_load = (j == w3);
            c.sc = sat15(idx); q.push_back(c); idx++;
         end
      end
      for (int j = 0; j <= we; j++) begin
         c = new_cyc(); c.busy = 1; c.tag = "exec";
         c.exec_start = (j == 0);
         c.exec_done  = (j == we);
         if (j == we) c.run = run_after;
         c.sc = sat15(idx); q.push_back(c); idx++;
      end
      if (abort_at >= 0 && abort_at < q.size()) begin
         for (int j = 0; j < abort_at; j++) plan.push_back(q[j]);
         p_reset();
      end else begin
         foreach (q[j]) plan.push_back(q[j]);
         chained = run_after;
      end
   endtask

   task automatic chk(input string tag, input int cyc, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      cyc_t        c;
      logic [15:0] ir;
      int          w1, w3, we, ab;
      n_cmp   = 0;
      n_mis   = 0;
      m_dop   = 3'd0;
      m_ibit  = 1'b0;
      chained = 1'b0;

      p_reset();
      p_idle(2);
      p_instr(16'h2123, 1, 0, 2, 1'b0, -1);
      p_idle(1);
      p_instr(16'hA123, 0, 2, 1, 1'b0, -1);
      p_instr(16'hF800, 0, 0, 0, 1'b0, -1);
      p_instr(16'h3456, 0, 0, 5, 1'b0, -1);
      p_idle(3);
      p_instr(16'h4001, 1, 0, 5, 1'b1, -1);
      p_instr(16'h9ABC, 0, 1, 0, 1'b0, -1);
      p_clr(1'b1);
      p_instr(16'h1111, 0, 0, 1, 1'b0, -1);
      p_instr(16'h5555, 4, 0, 1, 1'b0, 3);
      p_idle(1);
      p_instr(16'hB0F0, 10, 8, 3, 1'b0, -1);
      p_instr(16'hC00C, 0, 3, 2, 1'b0, 5);
      p_instr(16'h7007, 0, 0, 4, 1'b1, 4);

      for (int i = 0; i < 40; i++) begin
         if (!chained) begin
            if ($urandom_range(0, 3) == 0) p_clr(1'($urandom));
            p_idle($urandom_range(0, 2));
         end
         ir = 16'($urandom);
         if ($urandom_range(0, 3) == 0) ir[14:12] = 3'd7;
         w1 = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) w1 = 14;
         w3 = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) w3 = 13;
         we = $urandom_range(0, 6);
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : -1;
         p_instr(ir, w1, w3, we, 1'($urandom), ab);
      end
      p_idle(2);

      for (int k = 0; k < plan.size(); k++) begin
         c         = plan[k];
         rst_n     = c.rst_n;
         run       = c.run;
         clr_req   = c.clr_req;
         ir_in     = c.ir;
         mem_ack   = c.mem_ack;
         exec_done = c.exec_done;
         @(negedge clk);
         if (c.chk) begin
            chk({c.tag, ".ar_load"},    k, 16'(ar_load),    16'(c.ar_load));
            chk({c.tag, ".ar_inc"},     k, 16'(ar_inc),     16'd0);
            chk({c.tag, ".ar_clr"},     k, 16'(ar_clr),     16'(c.ar_clr));
            chk({c.tag, ".pc_load"},    k, 16'(pc_load),    16'd0);
            chk({c.tag, ".pc_inc"},     k, 16'(pc_inc),     16'(c.pc_inc));
            chk({c.tag, ".pc_clr"},     k, 16'(pc_clr),     16'(c.pc_clr));
            chk({c.tag, ".ir_load"},    k, 16'(ir_load),    16'(c.ir_load));
            chk({c.tag, ".mem_rd"},     k, 16'(mem_rd),     16'(c.mem_rd));
            chk({c.tag, ".bus_sel"},    k, 16'(bus_sel),    16'(c.bus));
            chk({c.tag, ".exec_start"}, k, 16'(exec_start), 16'(c.exec_start));
            chk({c.tag, ".d_op"},       k, 16'(d_op),       16'(c.d_op));
            chk({c.tag, ".i_bit"},      k, 16'(i_bit),      16'(c.i_bit));
            chk({c.tag, ".sc"},         k, 16'(sc),         16'(c.sc));
            chk({c.tag, ".busy"},       k, 16'(busy),       16'(c.busy));
            chk({c.tag, ".ar_excl"},    k, 16'($countones({ar_load, ar_inc, ar_clr}) <= 1), 16'd1);
            chk({c.tag, ".pc_excl"},    k, 16'($countones({pc_load, pc_inc, pc_clr}) <= 1), 16'd1);
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
